// File: rtl/bias_add_array.sv
// bias_add_array: two-stage valid/ready per-lane signed bias add; `define BIAS_SAT_EN for clamping with sat_o, else two's-complement wrap.
module bias_add_array #(
  parameter int LANES = 8,
  parameter int DATA_W = 32,
  parameter int BIAS_W = 32,
  parameter int OUT_W = 32,
  localparam int AW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    bias_we_i,
  input  logic [AW-1:0]           bias_addr_i,
  input  logic [BIAS_W-1:0]       bias_data_i,
  input  logic                    bias_clr_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [LANES*DATA_W-1:0] data_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [LANES*OUT_W-1:0]  data_o,
  output logic [LANES-1:0]        sat_o
);
  localparam int SW = ((DATA_W > BIAS_W) ? DATA_W : BIAS_W) + 1;
  logic signed [BIAS_W-1:0] r_bias [LANES];
  logic signed [SW-1:0] r_sum [LANES];
  logic signed [SW-1:0] w_sum [LANES];
  logic [LANES*OUT_W-1:0] w_res;
  logic [LANES-1:0] w_sat;
  logic [LANES*OUT_W-1:0] r_data;
  logic [LANES-1:0] r_sat;
  logic r_s1_valid, r_s2_valid;
  logic w_s1_load, w_s2_load;
  assign w_s2_load = !r_s2_valid || ready_i;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign ready_o = w_s1_load;
  assign valid_o = r_s2_valid;
  assign data_o = r_data;
  assign sat_o = r_sat;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign w_sum[k] = {{(SW-DATA_W){data_i[k*DATA_W+DATA_W-1]}}, data_i[k*DATA_W +: DATA_W]}
                    + {{(SW-BIAS_W){r_bias[k][BIAS_W-1]}}, r_bias[k]};
`ifdef BIAS_SAT_EN
    localparam logic signed [SW-1:0] MAX_V = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_V = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    logic w_hi, w_lo;
    assign w_hi = r_sum[k] > MAX_V;
    assign w_lo = r_sum[k] < MIN_V;
    assign w_res[k*OUT_W +: OUT_W] = w_hi ? MAX_V[OUT_W-1:0] : w_lo ? MIN_V[OUT_W-1:0] : r_sum[k][OUT_W-1:0];
    assign w_sat[k] = w_hi || w_lo;
`else
    logic w_unused_hi;
    assign w_unused_hi = ^r_sum[k];
    assign w_res[k*OUT_W +: OUT_W] = r_sum[k][OUT_W-1:0];
    assign w_sat[k] = 1'b0;
`endif
  end
  // a write lands after this edge's accept, so the accepted beat always sees the old bias
  always_ff @(posedge clk_i) begin
    if (rst_i || bias_clr_i)
      for (int k = 0; k < LANES; k++) r_bias[k] <= '0;
    else if (bias_we_i && 32'(bias_addr_i) < LANES)
      r_bias[bias_addr_i] <= bias_data_i;
  end
  always_ff @(posedge clk_i) begin
    if (w_s1_load && valid_i) r_sum <= w_sum;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_data <= '0;
      r_sat <= '0;
    end else begin
      if (w_s1_load) r_s1_valid <= valid_i;
      if (w_s2_load) r_s2_valid <= r_s1_valid;
      if (w_s2_load && r_s1_valid) begin
        r_data <= w_res;
        r_sat <= w_sat;
      end
    end
  end
endmodule

// File: tb/tb_bias_add_array.sv
// tb_bias_add_array: randomized bench for bias_add_array against a queue-based arithmetic reference model.
module tb_bias_add_array;
  localparam int L = 8;
  localparam int W = 32;
  typedef logic [L*W+L-1:0] beat_t;
  logic clk = 1'b0;
  logic rst, bias_we, bias_clr, valid_i, ready_i;
  logic [2:0] bias_addr;
  logic [W-1:0] bias_data;
  logic [L*W-1:0] data_i;
  logic ready_o, valid_o;
  logic [L*W-1:0] data_o;
  logic [L-1:0] sat_o;
  logic s_we, s_valid, s_ready_i, s_ready_o, s_valid_o;
  logic [2:0] s_addr;
  logic [7:0] s_bdata;
  logic [39:0] s_data_i;
  logic [44:0] s_data_o;
  logic [4:0] s_sat;
  int n_cmp = 0;
  int n_err = 0;
  longint bias_m [L];
  beat_t q[$];
  beat_t obs_q[$];
  beat_t exp_q[$];
  logic acc, fire, stall, cur_v, rdy_s, exp_rdy;
  beat_t cur;

  bias_add_array #(.LANES(L), .DATA_W(W), .BIAS_W(W), .OUT_W(W)) dut (
    .clk_i(clk), .rst_i(rst), .bias_we_i(bias_we), .bias_addr_i(bias_addr),
    .bias_data_i(bias_data), .bias_clr_i(bias_clr), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .sat_o(sat_o));

  bias_add_array #(.LANES(5), .DATA_W(8), .BIAS_W(8), .OUT_W(9)) dut_s (
    .clk_i(clk), .rst_i(rst), .bias_we_i(s_we), .bias_addr_i(s_addr),
    .bias_data_i(s_bdata), .bias_clr_i(1'b0), .valid_i(s_valid), .ready_o(s_ready_o),
    .data_i(s_data_i), .valid_o(s_valid_o), .ready_i(s_ready_i), .data_o(s_data_o), .sat_o(s_sat));

  always #5 clk = ~clk;

  function automatic beat_t model(input logic [L*W-1:0] d);
    logic [L*W-1:0] od;
    logic [L-1:0] os;
    longint s, mx, mn;
    mx = (longint'(1) <<< (W-1)) - 1;
    mn = -mx - 1;
    for (int k = 0; k < L; k++) begin
      s = longint'($signed(d[k*W +: W])) + bias_m[k];
      os[k] = 1'b0;
`ifdef BIAS_SAT_EN
      if (s > mx) begin s = mx; os[k] = 1'b1; end
      else if (s < mn) begin s = mn; os[k] = 1'b1; end
`endif
      od[k*W +: W] = s[W-1:0];
    end
    return {od, os};
  endfunction

  function automatic logic [L*W-1:0] rnd();
    logic [L*W-1:0] d;
    for (int k = 0; k < L; k++) d[k*W +: W] = $urandom;
    return d;
  endfunction

  // one cycle: sample at negedge+1, advance the model, return at the next negedge
  task automatic step();
    #1;
    acc = valid_i && ready_o && !rst;
    fire = valid_o && ready_i && !rst;
    exp_rdy = !(q.size() == 2 && !ready_i);
    stall = valid_o && !ready_i;
    cur = {data_o, sat_o};
    cur_v = valid_o;
    rdy_s = ready_o;
    if (fire) begin
      obs_q.push_back(cur);
      exp_q.push_back(q.size() > 0 ? q.pop_front() : ~cur);
    end
    if (acc) q.push_back(model(data_i));
    if (rst) begin
      q.delete();
      foreach (bias_m[k]) bias_m[k] = 0;
    end else if (bias_clr) begin
      foreach (bias_m[k]) bias_m[k] = 0;
    end else if (bias_we && bias_addr < L) begin
      bias_m[bias_addr] = longint'($signed(bias_data));
    end
    @(negedge clk);
  endtask

  task automatic idle();
    valid_i = 0; ready_i = 1; bias_we = 0; bias_clr = 0; bias_addr = 0; bias_data = 0; data_i = '0;
  endtask

  task automatic wbias(input int a, input logic [W-1:0] v);
    bias_we = 1; bias_addr = 3'(a); bias_data = v;
    step();
    bias_we = 0;
  endtask

  task automatic drain();
    valid_i = 0; ready_i = 1;
    for (int c = 0; c < 20 && q.size() > 0; c++) step();
  endtask

  task automatic test_reset();
    logic [L*W-1:0] d0;
    beat_t o, e;
    n_cmp++;
    if ({valid_o, data_o, sat_o} !== '0) begin n_err++; $display("FAIL reset_state: got %h exp 0", {valid_o, data_o, sat_o}); end
    rst = 0; idle();
    step();
    n_cmp++;
    if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b exp 1", ready_o); end
    wbias(1, 32'h1234); wbias(5, -77);
    valid_i = 1; ready_i = 0; data_i = rnd();
    repeat (3) step();
    rst = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++;
      if ({valid_o, data_o, sat_o} !== '0) begin n_err++; $display("FAIL midreset_out: got %h exp 0", {valid_o, data_o, sat_o}); end
    end
    obs_q.delete(); exp_q.delete();
    rst = 0; ready_i = 1; valid_i = 1; data_i = rnd(); d0 = data_i;
    step();
    drain();
    n_cmp++;
    if (obs_q.size() != 1) begin n_err++; $display("FAIL reset_count: got %0d exp 1", obs_q.size()); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (o !== {d0, {L{1'b0}}}) begin n_err++; $display("FAIL reset_zero_bias: got %h exp %h", o, {d0, {L{1'b0}}}); end
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL reset_model: got %h exp %h", o, e); end
    end
  endtask

  task automatic test_basic();
    logic [L*W-1:0] ed;
    beat_t o, e;
    idle();
    for (int k = 0; k < L; k++) wbias(k, 32'(k*10));
    for (int k = 0; k < L; k++) begin
      data_i[k*W +: W] = 32'(-100);
      ed[k*W +: W] = 32'(k*10 - 100);
    end
    valid_i = 1;
    step();
    n_cmp++;
    if (acc !== 1'b1) begin n_err++; $display("FAIL basic_accept: got %b exp 1", acc); end
    valid_i = 0;
    step();
    n_cmp++;
    if (cur_v !== 1'b0) begin n_err++; $display("FAIL basic_early: got valid %b exp 0", cur_v); end
    step();
    n_cmp++;
    if (fire !== 1'b1) begin n_err++; $display("FAIL basic_latency: got valid %b exp 1", fire); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (o !== {ed, {L{1'b0}}}) begin n_err++; $display("FAIL basic_lanes: got %h exp %h", o, {ed, {L{1'b0}}}); end
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL basic_model: got %h exp %h", o, e); end
    end
  endtask

  task automatic test_backpressure();
    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int sent = 0;
    logic prev_stall = 0;
    beat_t prev, o, e;
    idle();
    data_i = rnd();
    for (int c = 0; c < 60 && (sent < 6 || q.size() > 0); c++) begin
      valid_i = sent < 6; ready_i = pat[c % 6];
      step();
      n_cmp++;
      if (rdy_s !== exp_rdy) begin n_err++; $display("FAIL bp_ready: got %b exp %b", rdy_s, exp_rdy); end
      if (prev_stall) begin
        n_cmp++;
        if (!cur_v || cur !== prev) begin n_err++; $display("FAIL bp_hold: got %h exp %h", cur, prev); end
      end
      prev_stall = stall; prev = cur;
      if (acc) begin sent++; data_i = rnd(); end
    end
    n_cmp++;
    if (obs_q.size() != 6) begin n_err++; $display("FAIL bp_count: got %0d exp 6", obs_q.size()); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL bp_beat: got %h exp %h", o, e); end
    end
  endtask

  task automatic test_bias_race();
    beat_t o [4];
    beat_t e;
    int n;
    idle();
    wbias(2, 32'd7);
    valid_i = 1; bias_we = 1; bias_addr = 2; bias_data = 5;
    step();
    n_cmp++;
    if (acc !== 1'b1) begin n_err++; $display("FAIL race_accept: got %b exp 1", acc); end
    bias_we = 0;
    step();
    bias_clr = 1; bias_we = 1; bias_addr = 3; bias_data = 99;
    step();
    bias_clr = 0; bias_we = 0;
    step();
    drain();
    n = obs_q.size();
    n_cmp++;
    if (n != 4) begin n_err++; $display("FAIL race_count: got %0d exp 4", n); end
    for (int i = 0; i < 4 && obs_q.size() > 0; i++) begin
      o[i] = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (o[i] !== e) begin n_err++; $display("FAIL race_model: got %h exp %h", o[i], e); end
    end
    if (n == 4) begin
      n_cmp++;
      if (o[0][L+2*W +: W] !== 32'd7) begin n_err++; $display("FAIL race_old_bias: got %h exp 7", o[0][L+2*W +: W]); end
      n_cmp++;
      if (o[1][L+2*W +: W] !== 32'd5) begin n_err++; $display("FAIL race_new_bias: got %h exp 5", o[1][L+2*W +: W]); end
      n_cmp++;
      if (o[3] !== '0) begin n_err++; $display("FAIL race_clear: got %h exp 0", o[3]); end
    end
  endtask

  task automatic test_overflow();
    beat_t o [2];
    beat_t e;
    logic [W:0] x0, x1;
`ifdef BIAS_SAT_EN
    x0 = {1'b1, 32'h7FFF_FFFF}; x1 = {1'b1, 32'h8000_0000};
`else
    x0 = {1'b0, 32'h8000_0010}; x1 = {1'b0, 32'h7FFF_FFFF};
`endif
    idle();
    wbias(0, 32'h20);
    data_i[W-1:0] = 32'h7FFF_FFF0; valid_i = 1;
    step();
    valid_i = 0;
    wbias(0, 32'hFFFF_FFFF);
    data_i[W-1:0] = 32'h8000_0000; valid_i = 1;
    step();
    drain();
    n_cmp++;
    if (obs_q.size() != 2) begin n_err++; $display("FAIL ovf_count: got %0d exp 2", obs_q.size()); end
    for (int i = 0; i < 2 && obs_q.size() > 0; i++) begin
      o[i] = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (o[i] !== e) begin n_err++; $display("FAIL ovf_model: got %h exp %h", o[i], e); end
    end
    n_cmp++;
    if ({o[0][0], o[0][L +: W]} !== x0) begin n_err++; $display("FAIL ovf_pos: got %h exp %h", {o[0][0], o[0][L +: W]}, x0); end
    n_cmp++;
    if ({o[1][0], o[1][L +: W]} !== x1) begin n_err++; $display("FAIL ovf_neg: got %h exp %h", {o[1][0], o[1][L +: W]}, x1); end
  endtask

  task automatic test_throughput();
    int accs = 0;
    beat_t o, e;
    idle();
    for (int k = 0; k < L; k++) wbias(k, $urandom);
    valid_i = 1;
    for (int c = 0; c < 100; c++) begin
      data_i = rnd();
      step();
      if (acc) accs++;
    end
    valid_i = 0;
    repeat (2) step();
    n_cmp++;
    if (accs != 100) begin n_err++; $display("FAIL tp_accepts: got %0d exp 100", accs); end
    n_cmp++;
    if (obs_q.size() != 100) begin n_err++; $display("FAIL tp_outputs: got %0d exp 100", obs_q.size()); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL tp_beat: got %h exp %h", o, e); end
    end
    drain();
  endtask

  task automatic test_addr_range();
    logic [44:0] ed = {9'h034, 9'h001, 9'h001, 9'h001, 9'h001};
    s_ready_i = 1;
    s_we = 1;
    s_addr = 5; s_bdata = 8'h11; @(negedge clk);
    s_addr = 7; s_bdata = 8'h22; @(negedge clk);
    s_addr = 4; s_bdata = 8'h33; @(negedge clk);
    s_we = 0; s_data_i = {5{8'h01}}; s_valid = 1;
    #1;
    n_cmp++;
    if (s_ready_o !== 1'b1) begin n_err++; $display("FAIL range_ready: got %b exp 1", s_ready_o); end
    @(negedge clk);
    s_valid = 0;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({s_valid_o, s_data_o, s_sat} !== {1'b1, ed, 5'b0}) begin
      n_err++; $display("FAIL range_lanes: got %h exp %h", {s_valid_o, s_data_o, s_sat}, {1'b1, ed, 5'b0});
    end
  endtask

  initial begin
    rst = 1; idle();
    s_we = 0; s_valid = 0; s_ready_i = 1; s_addr = 0; s_bdata = 0; s_data_i = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_bias_race();
    test_overflow();
    test_throughput();
    test_addr_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
